// File: rtl/data_memory_responder_pkg.sv
// Shared encodings and defaults for the data/instruction memory responder.
// Access-length codes match the core's memoryLength field.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    MEM_LEN_BYTE = 2'd0,
    MEM_LEN_HALF = 2'd1,
    MEM_LEN_RSVD = 2'd2,
    MEM_LEN_WORD = 2'd3
  } memLen_t;

  localparam logic [31:0] MMIO_ADDR_DEFAULT     = 32'hFFFF_FFF0;
  localparam int          RAM_ADDR_BITS_DEFAULT = 12;

  // Byte-lane write enables for a little-endian store of the given length.
  function automatic logic [3:0] laneEnables(input logic [1:0] len, input logic [1:0] lane);
    case (len)
      MEM_LEN_BYTE: return 4'b0001 << lane;
      MEM_LEN_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      MEM_LEN_WORD: return 4'b1111;
      default:      return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Core-to-memory request/response bus: the core is master, the responder is slave.
interface data_memory_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] memoryAddress;
  logic [DATA_WIDTH-1:0] memoryDataWrite;
  logic [1:0]            memoryLength;
  logic                  store;
  logic                  load;
  logic                  loadUnsigned;
  logic [DATA_WIDTH-1:0] memoryDataRead;

  modport master (
    output memoryAddress, memoryDataWrite, memoryLength, store, load, loadUnsigned,
    input  memoryDataRead
  );

  modport slave (
    input  memoryAddress, memoryDataWrite, memoryLength, store, load, loadUnsigned,
    output memoryDataRead
  );
endinterface

// File: rtl/data_memory_responder_lane_extract.sv
// Combinational load alignment: picks the addressed byte/halfword from a raw
// little-endian word and sign- or zero-extends it.
module memory_lane_extract
  import data_memory_responder_pkg::*;
(
  input  logic [31:0] rawWord,
  input  logic [1:0]  lane,
  input  logic [1:0]  len,
  input  logic        loadUnsigned,
  output logic [31:0] result
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rawWord[{lane, 3'b000} +: 8];
    halfSel = lane[1] ? rawWord[31:16] : rawWord[15:0];
    case (len)
      MEM_LEN_BYTE: result = {{24{~loadUnsigned & byteSel[7]}}, byteSel};
      MEM_LEN_HALF: result = {{16{~loadUnsigned & halfSel[15]}}, halfSel};
      default:      result = rawWord;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Word-organised synchronous RAM with byte-lane writes, registered reads,
// one console MMIO register and a sticky first-fault recorder.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_BITS  = RAM_ADDR_BITS_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] MMIO_ADDR  = MMIO_ADDR_DEFAULT,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_responder_if.slave bus,
  output logic [DATA_WIDTH-1:0] mmioData,
  output logic                  mmioValid,
  output logic                  accessFault,
  output logic [DATA_WIDTH-1:0] faultAddress
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0] ram [DEPTH];

  logic [ADDR_BITS-1:0] wordIdx;
  logic [1:0]           lane;
  logic                 isMmio, inRange, aligned, lenOk, loadLegal, storeLegal;
  logic                 faultNow, ramWrite;
  logic [3:0]           laneEn;
  logic [31:0]          wrData;

  logic [31:0] readWord;
  logic [1:0]  readLane;
  logic [1:0]  readLen;
  logic        readUnsigned;

  always_comb begin
    wordIdx = bus.memoryAddress[ADDR_BITS+1:2];
    lane    = bus.memoryAddress[1:0];
    isMmio  = (bus.memoryAddress == MMIO_ADDR);
    inRange = isMmio || (bus.memoryAddress[DATA_WIDTH-1:ADDR_BITS+2] == '0);
    lenOk   = (bus.memoryLength != MEM_LEN_RSVD);
    case (bus.memoryLength)
      MEM_LEN_HALF: aligned = ~lane[0];
      MEM_LEN_WORD: aligned = (lane == 2'b00);
      default:      aligned = 1'b1;
    endcase
    loadLegal  = lenOk && aligned && inRange;
    // The console register only accepts full-word stores.
    storeLegal = loadLegal && (!isMmio || bus.memoryLength == MEM_LEN_WORD);
    faultNow   = (bus.store && !storeLegal) || (bus.load && !bus.store && !loadLegal)
               || (bus.load && bus.store);
    laneEn     = laneEnables(bus.memoryLength, lane);
    case (bus.memoryLength)
      MEM_LEN_BYTE: wrData = {4{bus.memoryDataWrite[7:0]}};
      MEM_LEN_HALF: wrData = {2{bus.memoryDataWrite[15:0]}};
      default:      wrData = bus.memoryDataWrite[31:0];
    endcase
    ramWrite = bus.store && storeLegal && !isMmio && !reset;
  end

  always_ff @(posedge clk) begin
    if (ramWrite) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (laneEn[b]) ram[wordIdx][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readWord     <= '0;
      readLane     <= '0;
      readLen      <= MEM_LEN_WORD;
      readUnsigned <= 1'b0;
      mmioData     <= '0;
      mmioValid    <= 1'b0;
      accessFault  <= 1'b0;
      faultAddress <= '0;
    end else begin
      mmioValid <= 1'b0;
      // A store wins over a simultaneous load, which leaves the read registers untouched.
      if (bus.store) begin
        if (storeLegal && isMmio) begin
          mmioData  <= bus.memoryDataWrite;
          mmioValid <= 1'b1;
        end
      end else if (bus.load) begin
        readLane     <= lane;
        readLen      <= bus.memoryLength;
        readUnsigned <= bus.loadUnsigned;
        if (!loadLegal)  readWord <= '0;
        else if (isMmio) readWord <= mmioData[31:0];
        else             readWord <= ram[wordIdx];
      end
      if (faultNow && !accessFault) begin
        accessFault  <= 1'b1;
        faultAddress <= bus.memoryAddress;
      end
    end
  end

  memory_lane_extract u_extract (
    .rawWord     (readWord),
    .lane        (readLane),
    .len         (readLen),
    .loadUnsigned(readUnsigned),
    .result      (bus.memoryDataRead)
  );

endmodule
